// File: rtl/trace_serialiser.sv
// Drains one trace element per frame from the trace buffer and emits it as
// SYNC, SEQ, payload (MSB first), XOR checksum on a valid/ready byte stream.
module trace_serialiser #(
   parameter int unsigned TRACE_WIDTH = 64,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   data_present,
   output logic                   data_request,
   input  logic [TRACE_WIDTH-1:0] trace_element_in,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [7:0]             out_byte,
   output logic                   busy,
   output logic [15:0]            frames_sent
);

   localparam int unsigned     NBYTES    = TRACE_WIDTH / 8;
   localparam int unsigned     CNT_W     = $clog2(NBYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT, CAPTURE, SYNC, SEQ, PAYLOAD, CHECK
   } state_t;

   state_t                 state, state_next;
   logic [TRACE_WIDTH-1:0] shift;
   logic [7:0]             seq;
   logic [7:0]             checksum;
   logic [CNT_W-1:0]       byte_cnt;

   // rst_n is active-high here: asserted (1) forces the FSM back to IDLE.
   always_ff @(posedge clk) begin
      if (rst_n) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next   = state;
      data_request = 1'b0;
      out_valid    = 1'b0;
      out_byte     = 8'h00;
      busy         = (state != IDLE);
      case (state)
         IDLE:    if (data_present) state_next = REQ;
         REQ: begin
            data_request = 1'b1;
            state_next   = WAIT;
         end
         WAIT:    state_next = CAPTURE;
         CAPTURE: state_next = SYNC;
         SYNC: begin
            out_valid = 1'b1;
            out_byte  = SYNC_BYTE;
            if (out_ready) state_next = SEQ;
         end
         SEQ: begin
            out_valid = 1'b1;
            out_byte  = seq;
            if (out_ready) state_next = PAYLOAD;
         end
         PAYLOAD: begin
            out_valid = 1'b1;
            out_byte  = shift[TRACE_WIDTH-1 -: 8];
            if (out_ready && byte_cnt == LAST_BYTE) state_next = CHECK;
         end
         CHECK: begin
            out_valid = 1'b1;
            out_byte  = checksum;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath advances only on an accepted byte, so a stalled sink sees stable data.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         shift       <= '0;
         seq         <= 8'h00;
         checksum    <= 8'h00;
         byte_cnt    <= '0;
         frames_sent <= 16'h0000;
      end else begin
         case (state)
            CAPTURE: begin
               shift    <= trace_element_in;
               checksum <= seq;
               byte_cnt <= '0;
            end
            PAYLOAD: if (out_ready) begin
               shift    <= shift << 8;
               checksum <= checksum ^ shift[TRACE_WIDTH-1 -: 8];
               byte_cnt <= byte_cnt + 1'b1;
            end
            CHECK: if (out_ready) begin
               seq         <= seq + 8'd1;
               frames_sent <= frames_sent + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_serialiser.sv
// Self-checking bench for trace_serialiser: a queue-based trace buffer model
// feeds elements, and a byte-level frame model predicts every accepted byte.
module tb_trace_serialiser;

   localparam int TW = 64;
   localparam int NB = TW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          data_present;
   logic          data_request;
   logic [TW-1:0] trace_element_in;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_byte;
   logic          busy;
   logic [15:0]   frames_sent;

   always #5 clk = ~clk;

   trace_serialiser #(.TRACE_WIDTH(TW), .SYNC_BYTE(8'hA5)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_present     (data_present),
      .data_request     (data_request),
      .trace_element_in (trace_element_in),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_byte         (out_byte),
      .busy             (busy),
      .frames_sent      (frames_sent)
   );

   typedef struct {
      logic [63:0] elem;
      logic [7:0]  seq;
      logic [7:0]  chk;
   } vec_t;

   vec_t vecs[6];

   int checks   = 0;
   int failures = 0;

   logic [63:0] src_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  seen_seq[$];
   logic [7:0]  last_frame[NB+3];
   logic [7:0]  model_seq;
   logic [7:0]  prev_byte;
   int          pos, model_frames, req_count, stall_count, cyc, rst_left;
   int          first_req_cyc, first_valid_cyc, last_valid_cyc;
   bit          prev_hold, prev_req, stall_en, dp_mask, mask_after_req;
   bit          rst_arm, rst_fired;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected frame for one element: sync, seq, payload MSB first, XOR of seq and payload.
   function automatic void push_frame(input logic [63:0] elem, input logic [7:0] s);
      logic [7:0] x;
      logic [7:0] b;
      x = s;
      exp_q.push_back(8'hA5);
      exp_q.push_back(s);
      for (int i = 0; i < NB; i++) begin
         b = 8'(elem >> (8 * (NB - 1 - i)));
         x = x ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(x);
   endfunction

   // One clock: monitor at the falling edge, buffer model and stimulus #1 after the rising edge.
   task automatic cycle();
      bit         req_now, acc, rst_edge;
      logic [7:0] e;
      @(negedge clk);
      if (!rst_n) begin
         if (prev_hold) begin
            check("stall_valid", out_valid, 1);
            check("stall_byte", out_byte, prev_byte);
         end
         if (pos != 0) check("valid_mid_frame", out_valid, 1);
         if (rst_arm && out_valid && pos == 4) begin
            rst_n     = 1'b1;
            rst_left  = 1;
            rst_arm   = 1'b0;
            rst_fired = 1'b1;
         end
      end
      req_now = data_request;
      if (req_now) begin
         check("req_single_cycle", prev_req, 0);
         req_count++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (out_valid && !rst_n) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         last_valid_cyc = cyc;
      end
      acc = out_valid && out_ready && !rst_n;
      if (acc) begin
         check("frame_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_byte", out_byte, e);
         end
         if (pos == 1) seen_seq.push_back(out_byte);
         last_frame[pos] = out_byte;
         pos++;
         if (pos == NB + 3) begin
            pos = 0;
            model_frames++;
         end
      end
      if (out_valid && !out_ready && !rst_n) stall_count++;
      prev_hold = out_valid && !out_ready && !rst_n;
      prev_byte = out_byte;
      prev_req  = req_now;
      @(posedge clk);
      cyc++;
      rst_edge = rst_n;
      #1;
      if (rst_edge) begin
         exp_q.delete();
         seen_seq.delete();
         model_seq    = 8'h00;
         model_frames = 0;
         pos          = 0;
         prev_hold    = 1'b0;
         prev_req     = 1'b0;
         if (rst_left > 0) rst_left--;
         if (rst_left == 0) rst_n = 1'b0;
      end
      if (req_now) begin
         check("pop_available", src_q.size() != 0, 1);
         if (src_q.size() != 0) begin
            trace_element_in = src_q.pop_front();
            if (!rst_edge) begin
               push_frame(trace_element_in, model_seq);
               model_seq++;
            end
         end
         if (mask_after_req) begin
            dp_mask        = 1'b1;
            mask_after_req = 1'b0;
         end
      end
      data_present = (src_q.size() != 0) && !dp_mask;
      out_ready    = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (i >= 2 && exp_q.size() == 0 && !busy && (src_q.size() == 0 || dp_mask)) begin
            done = 1'b1;
            break;
         end
      end
      check({name, "_done"}, done, 1);
   endtask

   task automatic do_reset(input int n);
      rst_n    = 1'b1;
      rst_left = n;
      repeat (n) cycle();
   endtask

   initial begin
      int r0, f0, c0;

      vecs[0] = '{64'h0123_4567_89AB_CDEF, 8'h00, 8'h00};
      vecs[1] = '{64'h0000_0000_0000_0000, 8'h01, 8'h01};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h02, 8'h02};
      vecs[3] = '{64'h8000_0000_0000_0001, 8'h03, 8'h82};
      vecs[4] = '{64'h1100_0000_0000_0000, 8'h04, 8'h15};
      vecs[5] = '{64'h0000_0000_0000_00A5, 8'h05, 8'hA0};

      rst_n            = 1'b1;
      rst_left         = 3;
      data_present     = 1'b0;
      out_ready        = 1'b1;
      trace_element_in = '0;
      model_seq        = 8'h00;
      prev_byte        = 8'h00;
      pos = 0; model_frames = 0; req_count = 0; stall_count = 0; cyc = 0;
      first_req_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
      prev_hold = 0; prev_req = 0; stall_en = 0; dp_mask = 0; mask_after_req = 0;
      rst_arm = 0; rst_fired = 0;
      repeat (3) cycle();

      // Idle after reset with nothing queued.
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("idle_request", data_request, 0);
         check("idle_valid", out_valid, 0);
         check("idle_busy", busy, 0);
         check("idle_frames", frames_sent, 16'd0);
      end
      check("idle_req_count", req_count, 0);

      // Table-driven single frames with out_ready held high.
      foreach (vecs[i]) begin
         first_req_cyc   = -1;
         first_valid_cyc = -1;
         last_valid_cyc  = -1;
         src_q.push_back(vecs[i].elem);
         cycle();
         c0 = cyc;
         wait_drain(60, "table");
         check("table_req_latency", first_req_cyc - c0, 1);
         check("table_valid_latency", first_valid_cyc - c0, 4);
         check("table_frame_len", last_valid_cyc - first_valid_cyc + 1, NB + 3);
         check("table_sync", last_frame[0], 8'hA5);
         check("table_seq", last_frame[1], vecs[i].seq);
         check("table_checksum", last_frame[NB+2], vecs[i].chk);
         check("table_frames", frames_sent, 16'(i + 1));
      end

      // Random sink stalls.
      stall_en    = 1'b1;
      stall_count = 0;
      src_q.push_back(64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 15; i++) src_q.push_back({$urandom, $urandom});
      wait_drain(1500, "stall");
      stall_en = 1'b0;
      check("stalls_seen", stall_count > 0, 1);
      check("stall_frames", frames_sent, 16'(model_frames));

      // 300 queued elements from reset: sequence number wraps at frame 257.
      do_reset(2);
      r0 = req_count;
      for (int i = 0; i < 300; i++) src_q.push_back({$urandom, $urandom});
      wait_drain(6000, "burst");
      check("burst_requests", req_count - r0, 300);
      check("burst_frames", frames_sent, 16'd300);
      check("burst_seq_count", seen_seq.size(), 300);
      if (seen_seq.size() > 256) begin
         check("seq_before_wrap", seen_seq[255], 8'hFF);
         check("seq_after_wrap", seen_seq[256], 8'h00);
      end

      // Reset during the third payload byte abandons the frame.
      src_q.push_back({$urandom, $urandom});
      rst_arm   = 1'b1;
      rst_fired = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (rst_fired) break;
      end
      check("midreset_fired", rst_fired, 1);
      check("midreset_valid", out_valid, 0);
      check("midreset_busy", busy, 0);
      check("midreset_frames", frames_sent, 16'd0);
      cycle();
      check("midreset_idle_valid", out_valid, 0);
      src_q.push_back(64'hDEAD_BEEF_0BAD_F00D);
      wait_drain(60, "postreset");
      check("postreset_sync", last_frame[0], 8'hA5);
      check("postreset_seq_count", seen_seq.size(), 1);
      if (seen_seq.size() > 0) check("postreset_seq", seen_seq[0], 8'h00);
      check("postreset_frames", frames_sent, 16'd1);

      // data_present drops in the cycle after REQ: one frame, one request.
      r0             = req_count;
      f0             = model_frames;
      mask_after_req = 1'b1;
      src_q.push_back({$urandom, $urandom});
      src_q.push_back({$urandom, $urandom});
      wait_drain(100, "drop");
      repeat (10) cycle();
      check("drop_requests", req_count - r0, 1);
      check("drop_frames", frames_sent, 16'(f0 + 1));
      check("drop_left", src_q.size(), 1);
      check("drop_busy", busy, 0);
      dp_mask = 1'b0;
      wait_drain(100, "drop2");
      check("drop2_requests", req_count - r0, 2);
      check("drop2_frames", frames_sent, 16'(f0 + 2));
      check("drop2_left", src_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
